// File: rtl/rf_writeback_checker.sv
`default_nettype none
// ============================================================================
// Module  : rf_writeback_checker
// Brief   : Compares retired register-file writes against a preloaded table of
//           expected (rd, data) pairs and reports pass, fail, mismatch and timeout.
//           Optional macro WB_X0_FILTER_EN discards write-backs to x0.
// Revision: 1.0  initial release
// ============================================================================
module rf_writeback_checker #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_W     = 5,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            exp_we,
    input  logic [$clog2(DEPTH)-1:0]        exp_idx,
    input  logic [REG_ADDR_W-1:0]           exp_rd,
    input  logic [XLEN-1:0]                 exp_data,
    input  logic [$clog2(DEPTH):0]          exp_count,
    input  logic                            start,
    input  logic                            wb_en,
    input  logic [REG_ADDR_W-1:0]           wb_rd,
    input  logic [XLEN-1:0]                 wb_data,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic                            fail,
    output logic [1:0]                      fail_code,
    output logic [$clog2(DEPTH)-1:0]        fail_idx,
    output logic [REG_ADDR_W-1:0]           fail_rd,
    output logic [XLEN-1:0]                 fail_data,
    output logic [$clog2(DEPTH):0]          match_count,
    output logic [$clog2(TIMEOUT_CYCLES):0] cycle_count
);

    localparam int c_idx_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_idx_w + 1;
    localparam int c_cyc_w = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [c_cnt_w-1:0] c_depth        = c_cnt_w'(DEPTH);
    localparam logic [c_cyc_w-1:0] c_timeout_last = c_cyc_w'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_code_none    = 2'd0;
    localparam logic [1:0] c_code_rd      = 2'd1;
    localparam logic [1:0] c_code_data    = 2'd2;
    localparam logic [1:0] c_code_timeout = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    // Expected table; intentionally outside reset so a program survives re-arming.
    logic [REG_ADDR_W-1:0] r_tbl_rd   [DEPTH];
    logic [XLEN-1:0]       r_tbl_data [DEPTH];

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_cnt_w-1:0]    r_count,       w_count_nxt;
    logic [c_idx_w-1:0]    r_ptr,         w_ptr_nxt;
    logic [c_cnt_w-1:0]    r_match_count, w_match_count_nxt;
    logic [c_cyc_w-1:0]    r_cycle_count, w_cycle_count_nxt;
    logic [1:0]            r_fail_code,   w_fail_code_nxt;
    logic [c_idx_w-1:0]    r_fail_idx,    w_fail_idx_nxt;
    logic [REG_ADDR_W-1:0] r_fail_rd,     w_fail_rd_nxt;
    logic [XLEN-1:0]       r_fail_data,   w_fail_data_nxt;
    logic                  r_busy, r_done, r_pass, r_fail;

    logic                  w_wb_valid;
    logic [c_cnt_w-1:0]    w_count_clamped;
    logic                  w_last;
    logic [REG_ADDR_W-1:0] w_exp_rd;
    logic [XLEN-1:0]       w_exp_data;

`ifdef WB_X0_FILTER_EN
    assign w_wb_valid = wb_en && (wb_rd != '0);
`else
    assign w_wb_valid = wb_en;
`endif

    assign w_count_clamped = (exp_count > c_depth) ? c_depth : exp_count;
    assign w_exp_rd        = r_tbl_rd[r_ptr];
    assign w_exp_data      = r_tbl_data[r_ptr];
    assign w_last          = (({1'b0, r_ptr} + c_cnt_w'(1)) == r_count);

    always_ff @(posedge clk) begin
        if (exp_we && (r_state != S_RUN)) begin
            r_tbl_rd[exp_idx]   <= exp_rd;
            r_tbl_data[exp_idx] <= exp_data;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_count_nxt       = r_count;
        w_ptr_nxt         = r_ptr;
        w_match_count_nxt = r_match_count;
        w_cycle_count_nxt = r_cycle_count;
        w_fail_code_nxt   = r_fail_code;
        w_fail_idx_nxt    = r_fail_idx;
        w_fail_rd_nxt     = r_fail_rd;
        w_fail_data_nxt   = r_fail_data;

        case (r_state)
            S_RUN: begin
                w_cycle_count_nxt = r_cycle_count + c_cyc_w'(1);
                if (w_wb_valid && (wb_rd != w_exp_rd)) begin
                    w_state_nxt     = S_FAIL;
                    w_fail_code_nxt = c_code_rd;
                    w_fail_idx_nxt  = r_ptr;
                    w_fail_rd_nxt   = wb_rd;
                    w_fail_data_nxt = wb_data;
                end else if (w_wb_valid && (wb_data != w_exp_data)) begin
                    w_state_nxt     = S_FAIL;
                    w_fail_code_nxt = c_code_data;
                    w_fail_idx_nxt  = r_ptr;
                    w_fail_rd_nxt   = wb_rd;
                    w_fail_data_nxt = wb_data;
                end else begin
                    if (w_wb_valid) begin
                        w_ptr_nxt         = r_ptr + c_idx_w'(1);
                        w_match_count_nxt = r_match_count + c_cnt_w'(1);
                    end
                    // A completing match on the last allowed cycle still passes.
                    if (w_wb_valid && w_last) begin
                        w_state_nxt = S_PASS;
                    end else if (r_cycle_count == c_timeout_last) begin
                        w_state_nxt     = S_FAIL;
                        w_fail_code_nxt = c_code_timeout;
                        w_fail_idx_nxt  = w_ptr_nxt;
                    end
                end
            end
            default: begin
                if (start) begin
                    w_count_nxt       = w_count_clamped;
                    w_ptr_nxt         = '0;
                    w_match_count_nxt = '0;
                    w_cycle_count_nxt = '0;
                    w_fail_code_nxt   = c_code_none;
                    w_fail_idx_nxt    = '0;
                    w_fail_rd_nxt     = '0;
                    w_fail_data_nxt   = '0;
                    w_state_nxt       = (w_count_clamped == '0) ? S_PASS : S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_ptr         <= '0;
            r_match_count <= '0;
            r_cycle_count <= '0;
            r_fail_code   <= '0;
            r_fail_idx    <= '0;
            r_fail_rd     <= '0;
            r_fail_data   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_ptr         <= w_ptr_nxt;
            r_match_count <= w_match_count_nxt;
            r_cycle_count <= w_cycle_count_nxt;
            r_fail_code   <= w_fail_code_nxt;
            r_fail_idx    <= w_fail_idx_nxt;
            r_fail_rd     <= w_fail_rd_nxt;
            r_fail_data   <= w_fail_data_nxt;
            r_busy        <= (w_state_nxt == S_RUN);
            r_done        <= (w_state_nxt == S_PASS) || (w_state_nxt == S_FAIL);
            r_pass        <= (w_state_nxt == S_PASS);
            r_fail        <= (w_state_nxt == S_FAIL);
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign fail_code   = r_fail_code;
    assign fail_idx    = r_fail_idx;
    assign fail_rd     = r_fail_rd;
    assign fail_data   = r_fail_data;
    assign match_count = r_match_count;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_rf_writeback_checker
// Brief   : Directed and randomized bench for rf_writeback_checker with a
//           run-level reference model of the expected outcome.
// Revision: 1.0  initial release
// ============================================================================
module tb_rf_writeback_checker;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int DEPTH = 4;
    localparam int TO   = 8;
    localparam int IW   = $clog2(DEPTH);
    localparam int CW   = IW + 1;
    localparam int YW   = $clog2(TO) + 1;
    localparam int L    = TO + 2;
`ifdef WB_X0_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            exp_we;
    logic [IW-1:0]   exp_idx;
    logic [RW-1:0]   exp_rd;
    logic [XLEN-1:0] exp_data;
    logic [CW-1:0]   exp_count;
    logic            start;
    logic            wb_en;
    logic [RW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            busy, done, pass, fail;
    logic [1:0]      fail_code;
    logic [IW-1:0]   fail_idx;
    logic [RW-1:0]   fail_rd;
    logic [XLEN-1:0] fail_data;
    logic [CW-1:0]   match_count;
    logic [YW-1:0]   cycle_count;

    always #5 clk = ~clk;

    rf_writeback_checker #(
        .XLEN(XLEN), .REG_ADDR_W(RW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_rd(exp_rd), .exp_data(exp_data),
        .exp_count(exp_count), .start(start),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .fail_code(fail_code), .fail_idx(fail_idx), .fail_rd(fail_rd),
        .fail_data(fail_data), .match_count(match_count), .cycle_count(cycle_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference table and per-run write-back event list
    int          m_rd   [DEPTH];
    logic [31:0] m_data [DEPTH];
    bit          ev_en   [L];
    int          ev_rd   [L];
    logic [31:0] ev_data [L];

    // Predicted outcome: x_res 0=still running, 1=pass, 2=fail
    int          x_res, x_code, x_idx, x_frd, x_match, x_cycles, x_n;
    logic [31:0] x_fdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exp_we = 1'b0; exp_idx = '0; exp_rd = '0; exp_data = '0;
        exp_count = '0; start = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic load(input int idx, input int rd, input logic [31:0] data);
        exp_we = 1'b1; exp_idx = IW'(idx); exp_rd = RW'(rd); exp_data = data;
        m_rd[idx] = rd; m_data[idx] = data;
        tick();
        exp_we = 1'b0;
    endtask

    task automatic clear_ev();
        for (int k = 0; k < L; k++) begin
            ev_en[k] = 1'b0; ev_rd[k] = 0; ev_data[k] = '0;
        end
    endtask

    task automatic set_ev(input int k, input int rd, input logic [31:0] data);
        ev_en[k] = 1'b1; ev_rd[k] = rd; ev_data[k] = data;
    endtask

    // Walk the event list in order, applying the matching rules directly.
    task automatic predict(input int cnt);
        x_n = (cnt > DEPTH) ? DEPTH : cnt;
        x_res = (x_n == 0) ? 1 : 0;
        x_code = 0; x_idx = 0; x_frd = 0; x_fdata = '0; x_match = 0; x_cycles = 0;
        for (int k = 0; k < L && x_res == 0; k++) begin
            x_cycles = k + 1;
            if (ev_en[k] && !(FILTER && ev_rd[k] == 0)) begin
                if (ev_rd[k] != m_rd[x_match]) begin
                    x_res = 2; x_code = 1; x_idx = x_match; x_frd = ev_rd[k]; x_fdata = ev_data[k];
                end else if (ev_data[k] != m_data[x_match]) begin
                    x_res = 2; x_code = 2; x_idx = x_match; x_frd = ev_rd[k]; x_fdata = ev_data[k];
                end else begin
                    x_match++;
                    if (x_match == x_n) x_res = 1;
                end
            end
            if (x_res == 0 && k == TO - 1) begin
                x_res = 2; x_code = 3; x_idx = x_match;
            end
        end
    endtask

    task automatic do_run(input int cnt, input bit junk, input bit wr0);
        predict(cnt);
        exp_count = CW'(cnt);
        start = 1'b1;
        if (wr0) begin
            exp_we = 1'b1; exp_idx = '0; exp_rd = RW'(m_rd[0]); exp_data = m_data[0];
        end
        tick();
        start = 1'b0; exp_we = 1'b0;
        chk("start_busy", busy, x_n > 0);
        chk("start_pass", pass, x_n == 0);
        chk("start_cycle_count", cycle_count, 0);
        chk("start_match_count", match_count, 0);
        chk("start_fail_code", fail_code, 0);
        for (int k = 0; k < L; k++) begin
            wb_en = ev_en[k]; wb_rd = RW'(ev_rd[k]); wb_data = ev_data[k];
            if (junk && k < x_cycles) begin
                exp_we = 1'(($urandom % 2)); exp_idx = IW'($urandom);
                exp_rd = RW'($urandom); exp_data = $urandom;
                start = 1'(($urandom % 2)); exp_count = CW'($urandom);
            end else begin
                exp_we = 1'b0; start = 1'b0;
            end
            tick();
            chk("run_cycle_count", cycle_count, (k + 1 < x_cycles) ? k + 1 : x_cycles);
            chk("run_busy", busy, k + 1 < x_cycles);
        end
        idle_inputs();
        chk("end_pass", pass, x_res == 1);
        chk("end_fail", fail, x_res == 2);
        chk("end_done", done, x_res != 0);
        chk("end_fail_code", fail_code, x_code);
        chk("end_fail_idx", fail_idx, x_idx);
        chk("end_fail_rd", fail_rd, x_frd);
        chk("end_fail_data", fail_data, x_fdata);
        chk("end_match_count", match_count, x_match);
    endtask

    task automatic gen_events();
        int g = 0;
        int r;
        clear_ev();
        for (int k = 0; k < L; k++) begin
            if ($urandom % 3 != 0) begin
                r = $urandom % 10;
                if (r < 7 && g < DEPTH) begin
                    set_ev(k, m_rd[g], m_data[g]); g++;
                end else if (r < 8) set_ev(k, 0, $urandom);
                else if (r < 9) set_ev(k, m_rd[g % DEPTH], $urandom);
                else set_ev(k, $urandom % 32, m_data[g % DEPTH]);
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin m_rd[i] = 0; m_data[i] = '0; end
        tick(); tick();
        chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);         chk("rst_fail", fail, 0);
        chk("rst_fail_code", fail_code, 0); chk("rst_fail_idx", fail_idx, 0);
        chk("rst_fail_rd", fail_rd, 0);   chk("rst_fail_data", fail_data, 0);
        chk("rst_match_count", match_count, 0); chk("rst_cycle_count", cycle_count, 0);
        reset = 1'b1;
        tick();

        // In-order match of three entries
        load(0, 1, 51); load(1, 2, 3); load(2, 3, 6);
        clear_ev(); set_ev(0, 1, 51); set_ev(1, 2, 3); set_ev(2, 3, 6);
        do_run(3, 0, 0);
        chk("t1_pass", pass, 1); chk("t1_match", match_count, 3); chk("t1_code", fail_code, 0);

        // Data mismatch on the second entry
        clear_ev(); set_ev(0, 1, 51); set_ev(1, 2, 4);
        do_run(3, 0, 0);
        chk("t2_fail", fail, 1); chk("t2_code", fail_code, 2); chk("t2_idx", fail_idx, 1);
        chk("t2_rd", fail_rd, 2); chk("t2_data", fail_data, 4); chk("t2_match", match_count, 1);

        // rd mismatch wins over data mismatch
        clear_ev(); set_ev(0, 1, 51); set_ev(1, 5, 3);
        do_run(3, 0, 0);
        chk("t3_code", fail_code, 1); chk("t3_idx", fail_idx, 1); chk("t3_rd", fail_rd, 5);

        // Timeout, then a final match on the last allowed cycle
        clear_ev();
        do_run(1, 0, 0);
        chk("t4_code", fail_code, 3); chk("t4_cycles", cycle_count, TO); chk("t4_idx", fail_idx, 0);
        clear_ev(); set_ev(TO - 1, 1, 51);
        do_run(1, 0, 0);
        chk("t4b_pass", pass, 1); chk("t4b_cycles", cycle_count, TO);

        // Empty program passes immediately; re-arm from PASS
        clear_ev();
        do_run(0, 0, 0);
        chk("t5_pass", pass, 1);
        clear_ev(); set_ev(1, 1, 51);
        do_run(1, 0, 0);
        chk("t5b_pass", pass, 1); chk("t5b_match", match_count, 1);

        // Writes to x0 interleaved with expected writes
        clear_ev(); set_ev(0, 1, 51); set_ev(1, 0, 123); set_ev(2, 2, 3);
        set_ev(3, 0, 123); set_ev(4, 3, 6);
        do_run(3, 0, 0);
        if (FILTER) begin
            chk("t6_pass", pass, 1);
        end else begin
            chk("t6_code", fail_code, 1); chk("t6_rd", fail_rd, 0); chk("t6_idx", fail_idx, 1);
        end

        // exp_count above DEPTH clamps
        load(3, 9, 99);
        clear_ev(); set_ev(0, 1, 51); set_ev(1, 2, 3); set_ev(2, 3, 6); set_ev(3, 9, 99);
        do_run(7, 0, 0);
        chk("t7_pass", pass, 1); chk("t7_match", match_count, DEPTH);

        // Reset mid-run returns to IDLE; table survives
        exp_count = CW'(3); start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("t8_busy", busy, 0); chk("t8_done", done, 0);
        chk("t8_cycles", cycle_count, 0); chk("t8_match", match_count, 0);
        reset = 1'b1;
        clear_ev(); set_ev(0, 1, 51); set_ev(1, 2, 3); set_ev(2, 3, 6);
        do_run(3, 0, 0);
        chk("t8_pass", pass, 1);

        // Randomized programs with dropped writes/starts during RUN
        for (int it = 0; it < 40; it++) begin
            bit wr0;
            for (int i = 0; i < DEPTH; i++) begin
                if ($urandom % 2 == 0)
                    load(i, ($urandom % 8 == 0) ? 0 : 1 + ($urandom % 31), $urandom);
            end
            wr0 = 1'($urandom % 2);
            if (wr0) begin
                m_rd[0] = 1 + ($urandom % 31); m_data[0] = $urandom;
            end
            gen_events();
            do_run($urandom % 8, 1, wr0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_writeback_checker.md
Name: rf_writeback_checker

Overview:
- Synthesizable self-checking monitor for core-level tests.
- Sits beside the core and taps the register-file write-back port (enable, rd, data).
- Compares each retired write against a preloaded table of expected (rd, data) pairs, in order.
- Reports pass/fail, the first mismatch, and timeout, so directed programs are checked in-sim or on-FPGA without waveform inspection.

Parameters:
XLEN, 32, data width of write-back and expected values
REG_ADDR_W, 5, width of register index (32 architectural registers)
DEPTH, 16, number of expected-table entries
TIMEOUT_CYCLES, 1024, RUN cycles allowed before a timeout fail (must be >=1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
exp_we  in  1  write one expected-table entry
exp_idx  in  $clog2(DEPTH)  table entry index
exp_rd  in  REG_ADDR_W  expected destination register
exp_data  in  XLEN  expected write data
exp_count  in  $clog2(DEPTH)+1  number of valid entries, sampled at start
start  in  1  arm/re-arm the check
wb_en  in  1  register-file write strobe from core
wb_rd  in  REG_ADDR_W  written register index
wb_data  in  XLEN  written data
busy  out  1  state is RUN
done  out  1  state is PASS or FAIL
pass  out  1  state is PASS
fail  out  1  state is FAIL
fail_code  out  2  0 none, 1 rd mismatch, 2 data mismatch, 3 timeout
fail_idx  out  $clog2(DEPTH)  table index at failure
fail_rd  out  REG_ADDR_W  observed rd at mismatch
fail_data  out  XLEN  observed data at mismatch
match_count  out  $clog2(DEPTH)+1  entries matched so far
cycle_count  out  $clog2(TIMEOUT_CYCLES)+1  cycles spent in RUN

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; all outputs 0; ptr, counters and fail capture cleared. Table contents are not cleared.
- FSM states: IDLE, RUN, PASS, FAIL. All outputs are registered.
- IDLE/PASS/FAIL with start=1:
  - Latch exp_count; clear ptr, match_count, cycle_count, fail_code, fail_idx, fail_rd, fail_data.
  - Next state is RUN, or PASS directly if exp_count==0.
  - exp_count>DEPTH is clamped to DEPTH.
- start in RUN is ignored.
- exp_we writes table[exp_idx] only when not in RUN; writes in RUN are dropped. A write and start in the same cycle: the write lands first; start uses the updated table for entry 0 onward.
- RUN:
  - cycle_count increments every cycle.
  - If wb_en: compare against table[ptr]. rd mismatch takes priority over data mismatch.
  - Match: ptr and match_count increment. If ptr was the last valid entry, next state is PASS.
  - Mismatch: next state FAIL; capture fail_code (1 or 2), fail_idx=ptr, fail_rd=wb_rd, fail_data=wb_data.
- Timeout: cycle_count reaching TIMEOUT_CYCLES-1 with no completing match sets FAIL, fail_code=3, fail_idx=ptr. A final match in the same cycle as timeout wins (PASS).
- Latency: result flags assert on the clock edge that samples the deciding wb_en, visible the following cycle.
- wb_en after PASS/FAIL is ignored; results hold until start or reset.
- Reset asserted mid-RUN: immediate return to IDLE as above.

Optional Feature:
- Macro WB_X0_FILTER_EN.
- Defined: wb_en with wb_rd==0 is discarded before comparison; it does not advance ptr or cause a mismatch, matching writes the core performs to the hardwired-zero register.
- Undefined: rd==0 writes are compared like any other and must appear in the table.

Test Plan:
- Load table {(1,51),(2,3),(3,6)}, start, drive wb (1,51),(2,3),(3,6) on three cycles -> pass=1, match_count=3, fail_code=0.
- Same table, drive (1,51),(2,4) -> fail=1, fail_code=2, fail_idx=1, fail_rd=2, fail_data=4, match_count=1.
- Same table, drive (1,51),(5,3) -> fail_code=1 (rd beats data), fail_idx=1, fail_rd=5.
- TIMEOUT_CYCLES=8, exp_count=1, no wb_en -> fail_code=3 after 8 RUN cycles; final match on cycle 8 instead -> pass=1.
- exp_count=0, start -> pass next cycle, busy never 1; start again from PASS with exp_count=1 -> RUN, counters cleared.
- With WB_X0_FILTER_EN, interleave (0,123) between expected writes -> pass=1; without it -> fail_code=1, fail_rd=0.
